// File: rtl/apb_counter_regif.sv
// APB3 register front end for the 4-bit mod counter.
// One wait state, wrap detection, sticky flag, saturating wrap count, irq.
module apb_counter_regif #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              cnt_load,
  output logic              cnt_mode,
  output logic [CNT_W-1:0]  cnt_data,
  input  logic [CNT_W-1:0]  cnt_value,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nx;
  logic   commit;

  logic              irq_en;
  logic              wrap_flag;
  logic [WCNT_W-1:0] wrap_cnt;
  logic [CNT_W-1:0]  prev_value;
  logic              load_d;
  logic              ld_pend;
  logic [CNT_W-1:0]  ld_val;

  logic              unmapped;
  logic [1:0]        sel;
  logic              err;
  logic              wr;
  logic              wr_ctrl;
  logic              wr_load;
  logic              wr_stat;
  logic              wrap_evt;
  logic [DATA_W-1:0] rdata;
  logic              unused;

  assign unmapped = |paddr[ADDR_W-1:4];
  assign sel      = paddr[3:2];
  assign err      = unmapped | (pwrite & (sel == 2'd2));
  assign wr       = commit & pwrite & ~unmapped;
  assign wr_ctrl  = wr & (sel == 2'd0);
  assign wr_load  = wr & (sel == 2'd1);
  assign wr_stat  = wr & (sel == 2'd3);
  assign unused   = ^{pwdata[DATA_W-1:CNT_W], paddr[1:0]};

  assign wrap_evt = (prev_value != '0) & (cnt_value == '0)
                  & ~load_d & ~cnt_load;

  // Transfer sequencing: accept, one wait state, complete.
  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    unique case (state)
      S_IDLE: if (psel & penable) state_nx = S_WAIT;
      S_WAIT: begin
        if (!psel) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_DONE;
          commit   = 1'b1;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rdata = '0;
    if (!unmapped) begin
      unique case (sel)
        2'd0: rdata[1:0] = {irq_en, cnt_mode};
        2'd1: rdata[CNT_W-1:0] = cnt_data;
        2'd2: rdata[CNT_W-1:0] = cnt_value;
        2'd3: begin
          rdata[0]          = wrap_flag;
          rdata[8+:WCNT_W]  = wrap_cnt;
        end
        default: rdata = '0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Registered APB response, held for the single DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      pready  <= commit;
      pslverr <= commit & err;
      prdata  <= (commit & ~pwrite) ? rdata : '0;
    end
  end

  // Control registers; a LOAD write is staged so data and pulse land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_mode <= 1'b0;
      irq_en   <= 1'b0;
      ld_pend  <= 1'b0;
      ld_val   <= '0;
      cnt_load <= 1'b0;
      cnt_data <= '0;
      load_d   <= 1'b0;
    end else begin
      if (wr_ctrl) {irq_en, cnt_mode} <= pwdata[1:0];
      ld_pend <= wr_load;
      if (wr_load) ld_val <= pwdata[CNT_W-1:0];
      cnt_load <= ld_pend;
      if (ld_pend) cnt_data <= ld_val;
      load_d <= cnt_load;
    end
  end

  // Wrap tracking: sticky flag, saturating count, level irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_value <= '0;
      wrap_flag  <= 1'b0;
      wrap_cnt   <= '0;
      irq        <= 1'b0;
    end else begin
      prev_value <= cnt_value;
      if (wrap_evt) wrap_flag <= 1'b1;
      else if (wr_stat & pwdata[0]) wrap_flag <= 1'b0;
      if (wr_stat & pwdata[1])
        wrap_cnt <= wrap_evt ? WCNT_W'(1) : '0;
      else if (wrap_evt && (wrap_cnt != '1))
        wrap_cnt <= wrap_cnt + WCNT_W'(1);
      irq <= irq_en & wrap_flag;
    end
  end

endmodule

// File: tb/tb_apb_counter_regif.sv
// Randomized bench for apb_counter_regif.
// Reference model tracks register state from the register-map rules.
module tb_apb_counter_regif;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        cnt_load, cnt_mode;
  logic [3:0]  cnt_data, cnt_value;
  logic        irq;

  apb_counter_regif dut (
    .clk(clk), .reset(reset),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr),
    .cnt_load(cnt_load), .cnt_mode(cnt_mode),
    .cnt_data(cnt_data), .cnt_value(cnt_value),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;
  bit run = 0;

  logic [3:0] m_prev, m_data, m_ldv;
  bit m_loadd, m_pulse, m_pulse_nx;
  bit m_flag, m_flag_pre, m_mode, m_irqen, m_irq, m_evt;
  int m_wcnt, m_wcnt_pre;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, advanced once per rising edge.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_prev = 0; m_data = 0; m_ldv = 0;
      m_loadd = 0; m_pulse = 0; m_pulse_nx = 0;
      m_flag = 0; m_flag_pre = 0; m_mode = 0; m_irqen = 0;
      m_irq = 0; m_evt = 0; m_wcnt = 0; m_wcnt_pre = 0;
    end else begin
      m_evt = (m_prev != 0) && (cnt_value == 0) && !m_loadd && !m_pulse;
      m_flag_pre = m_flag;
      m_wcnt_pre = m_wcnt;
      m_irq = m_irqen && m_flag;
      if (m_evt) begin
        m_flag = 1;
        if (m_wcnt < 255) m_wcnt++;
      end
      m_loadd = m_pulse;
      m_pulse = m_pulse_nx;
      if (m_pulse_nx) m_data = m_ldv;
      m_pulse_nx = 0;
      m_prev = cnt_value;
    end
  end

  // Per-cycle output checks against the model.
  initial forever begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      check("cnt_load", cnt_load, m_pulse);
      check("cnt_data", cnt_data, m_data);
      check("cnt_mode", cnt_mode, m_mode);
      check("irq", irq, m_irq);
      if (!pready) begin
        check("prdata_idle", prdata, 0);
        check("pslverr_idle", pslverr, 0);
      end
    end
  end

  // Simple counter model: loads on pulse, steps when running.
  initial forever begin
    @(negedge clk);
    if (cnt_load === 1'b1) cnt_value = cnt_data;
    else if (run && $urandom_range(3) != 0)
      cnt_value = cnt_mode ? cnt_value - 4'd1 : cnt_value + 4'd1;
  end

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    logic [31:0] v;
    v = 0;
    if (a < 8'd16) begin
      case (a[3:2])
        2'd0: v = {30'd0, m_irqen, m_mode};
        2'd1: v = {28'd0, m_data};
        2'd2: v = {28'd0, m_prev};
        default: v = (m_wcnt_pre << 8) | 32'(m_flag_pre);
      endcase
    end
    return v;
  endfunction

  task automatic apb(input bit wr, input logic [7:0] a,
                     input logic [31:0] d, output logic [31:0] rd);
    int n;
    bit got;
    bit e_err;
    logic [31:0] e_rd;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1;
    n = 0; got = 0; rd = 0;
    while (!got && n < 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pready) got = 1;
    end
    check("pready_seen", 32'(got), 1);
    check("pready_lat", n, 2);
    if (got) begin
      rd = prdata;
      e_err = (a >= 8'd16) || (wr && a[3:2] == 2'd2);
      check("pslverr", pslverr, e_err);
      if (!wr) begin
        e_rd = exp_rd(a);
        check("prdata", prdata, e_rd);
      end else if (a < 8'd16) begin
        case (a[3:2])
          2'd0: begin m_mode = d[0]; m_irqen = d[1]; end
          2'd1: begin m_ldv = d[3:0]; m_pulse_nx = 1; end
          2'd3: begin
            if (d[0]) m_flag = m_evt;
            if (d[1]) m_wcnt = m_evt ? 1 : 0;
          end
          default: ;
        endcase
      end
    end
    psel = 0; penable = 0;
  endtask

  task automatic apb_rst_mid(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1;
    @(posedge clk);
    @(negedge clk);
    check("wait_pready", pready, 0);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_pready", pready, 0);
    reset = 0; psel = 0; penable = 0;
  endtask

  logic [31:0] rd, sv;
  logic [7:0]  ra;

  initial begin
    reset = 1; psel = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; cnt_value = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk_en = 1;
    check("rst_prdata", prdata, 0);
    check("rst_pready", pready, 0);
    check("rst_pslverr", pslverr, 0);
    check("rst_irq", irq, 0);

    for (int i = 0; i < 4; i++) apb(0, 8'(i * 4), 0, rd);

    apb(1, 8'h04, 32'h9, rd);
    @(negedge clk);
    check("load_pulse", cnt_load, 1);
    check("load_data", cnt_data, 4'h9);
    @(negedge clk);
    check("load_once", cnt_load, 0);
    apb(0, 8'h08, 0, rd);
    check("count_9", rd, 32'h9);

    apb(1, 8'h00, 32'h2, rd);
    for (int v = 10; v <= 16; v++) begin
      @(negedge clk);
      cnt_value = 4'(v);
    end
    repeat (2) @(negedge clk);
    apb(0, 8'h0C, 0, rd);
    check("wrap_status", rd, 32'h101);
    check("irq_set", irq, 1);
    apb(1, 8'h0C, 32'h1, rd);
    repeat (2) @(negedge clk);
    check("irq_clr", irq, 0);

    cnt_value = 4'd5;
    apb(0, 8'h0C, 0, sv);
    apb(1, 8'h04, 32'h0, rd);
    repeat (3) @(negedge clk);
    apb(0, 8'h0C, 0, rd);
    check("load0_nowrap", rd[15:8], sv[15:8]);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk); cnt_value = 4'd1;
      @(negedge clk); cnt_value = 4'd0;
    end
    @(negedge clk);
    apb(0, 8'h0C, 0, rd);
    check("wcnt_sat", rd[15:8], 8'd255);
    apb(1, 8'h0C, 32'h2, rd);
    apb(0, 8'h0C, 0, rd);
    check("wcnt_clr", rd[15:8], 8'd0);

    apb(1, 8'h08, 32'h3, rd);
    apb(0, 8'h10, 0, rd);
    check("unmap_rd", rd, 0);
    apb(1, 8'h20, 32'h3, rd);
    apb(0, 8'h00, 0, rd);
    apb(0, 8'h04, 0, rd);

    apb(1, 8'h00, 32'h1, rd);
    apb_rst_mid(8'h04, 32'hA);
    apb(0, 8'h04, 0, rd);
    check("rst_nocommit", rd, 0);
    apb(0, 8'h00, 0, rd);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(9) == 0) run = ~run;
      if ($urandom_range(3) == 0) ra = 8'($urandom_range(255));
      else ra = 8'($urandom_range(15));
      apb($urandom_range(1) == 1, ra, $urandom, rd);
      repeat ($urandom_range(3)) @(negedge clk);
    end
    run = 0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
